irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Multi-source interrupt controller in front of the core's special-register IRQ input.
//  Synchronises and latches up to N_SRC peripheral requests, masks them, and picks the
//  lowest-index pending source. Drives the single irq line with a handshake matched to the
//  core's IRQ-enable sequencing. Software reads and writes it through a small register port.
// PARAMETERS
//  N_SRC     8   number of interrupt sources, 1..16
//  SYNC_EN   1   1 = 2-flop synchroniser on src_irq; 0 = sources already in the clk domain
// PORTS
//  clk        in   1      core clock, all state on posedge
//  rst        in   1      synchronous, active-high reset
//  src_irq    in   N_SRC  raw peripheral requests
//  irq_en_in  in   1      core IRQ-enable bit (rt_mode IRQEN), sampled each cycle
//  irq_ack    in   1      1-cycle pulse: core has taken the IRQ (PC vectored to 0x1)
//  irq_out    out  1      interrupt request to the core (registered)
//  reg_we     in   1      register write strobe
//  reg_addr   in   2      0 MASK, 1 PENDING, 2 EDGE_SEL, 3 CAUSE
//  reg_wdata  in   16     write data
//  reg_rdata  out  16     combinational read of reg_addr; bits >= N_SRC read 0
// BEHAVIOUR
//  Reset: irq_out=0, MASK=0, PENDING=0, EDGE_SEL=all 1, CAUSE=16'hFFFF, state=IDLE, sync flops=0.
//  Input path: s = SYNC_EN ? sync2(src_irq) : src_irq; prev register s_d for edge detect.
//  PENDING[i]:
//   - EDGE_SEL[i]=1: set on s & ~s_d. Cleared by a write to PENDING with wdata[i]=1 (W1C).
//     Also cleared by irq_ack when i==cur. Set wins over any clear in the same cycle.
//   - EDGE_SEL[i]=0: PENDING[i] = s[i] (level, not latched). W1C and ack have no effect.
//  req = PENDING & MASK; cur = lowest index set in req (priority encoder, 4-bit id).
//  FSM (registered, 2-bit state):
//   IDLE:   irq_out=0. If irq_en_in & |req: latch cur_id<=cur, irq_out<=1 -> ASSERT.
//   ASSERT: irq_out=1, cur_id frozen; later MASK/PENDING changes do not alter it.
//           irq_ack -> irq_out<=0, CAUSE<=cur_id, edge-clear PENDING[cur_id] -> DRAIN.
//           else ~irq_en_in (software disabled) -> irq_out<=0, CAUSE unchanged -> IDLE.
//   DRAIN:  irq_out=0. Wait for ~irq_en_in (core clears IRQEN once irq falls) -> IDLE.
//           IDLE then re-arms only when software/iret sets irq_en_in again.
//  Latency: edge on src_irq -> irq_out high 3 cycles (SYNC_EN=1) or 1 cycle (SYNC_EN=0),
//   given MASK set, irq_en_in=1 and state IDLE.
//  irq_ack outside ASSERT is ignored. Register writes in any state take effect next cycle.
//   A MASK write that clears the bit of cur_id does not withdraw a request already asserted.
//  CAUSE holds the id of the last acknowledged source (read-only; writes ignored).
//  PENDING reads return the raw (unmasked) vector. MASK and EDGE_SEL are read/write.
//  Reset mid-operation (any state): all state returns to reset values next edge; irq_out=0.
// STRUCTURE
//  irq_pkg: state enum {IDLE, ASSERT, DRAIN}; localparams REG_MASK=0, REG_PEND=1,
//   REG_EDGE=2, REG_CAUSE=3; CAUSE_NONE=16'hFFFF.
//  Sub-module irq_prio_enc: N_SRC-bit vector -> {valid, 4-bit lowest-set index}; combinational.
//  Top: sync/edge detect, PENDING/MASK/EDGE_SEL regs, FSM, read mux.
// TESTING
//  1 SYNC_EN=1, MASK=0x0004, irq_en_in=1, pulse src_irq[2] -> irq_out=1 on cycle 3;
//    irq_ack -> irq_out=0 next cycle, CAUSE=2, PENDING=0.
//  2 Edges on src 5 and 1 in the same cycle, MASK=0xFF -> cur_id=1. After ack,
//    irq_en_in 1->0->1 -> second IRQ issued with CAUSE=5.
//  3 EDGE_SEL[3]=0, src_irq[3] held high through ack -> PENDING[3] stays 1; after re-enable,
//    IRQ re-asserts. Drop src_irq[3] -> PENDING[3]=0.
//  4 W1C PENDING=0x0010 in the same cycle as a new edge on src 4 -> PENDING[4]=1 (set wins).
//  5 In ASSERT, drop irq_en_in before ack -> irq_out=0 next cycle, CAUSE unchanged,
//    PENDING kept, state IDLE.
//  6 rst pulse while in ASSERT with irq_out=1 -> next cycle irq_out=0, MASK=0,
//    CAUSE=0xFFFF, EDGE_SEL=0xFF.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_DRAIN  = 2'd2
  } irq_state_e;

  localparam logic [1:0]  REG_MASK   = 2'd0;
  localparam logic [1:0]  REG_PEND   = 2'd1;
  localparam logic [1:0]  REG_EDGE   = 2'd2;
  localparam logic [1:0]  REG_CAUSE  = 2'd3;
  localparam logic [15:0] CAUSE_NONE = 16'hFFFF;

endpackage

// File: rtl/irq_ctrl_if.sv
// Core-facing IRQ handshake plus the software register port.
interface irq_ctrl_if;

  logic        irq_en_in;
  logic        irq_ack;
  logic        irq_out;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;

  modport master (
    output irq_en_in, irq_ack, reg_we, reg_addr, reg_wdata,
    input  irq_out, reg_rdata
  );

  modport slave (
    input  irq_en_in, irq_ack, reg_we, reg_addr, reg_wdata,
    output irq_out, reg_rdata
  );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder: vector -> {valid, 4-bit index}.
module irq_prio_enc #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [3:0]   idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (vec[i-1]) idx = 4'(i - 1);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller driving the core's single IRQ line.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N_SRC   = 8,
  parameter int unsigned SYNC_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_irq,
  irq_ctrl_if.slave        bus
);

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] s_prev_q, s_prev_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [15:0]      cause_q, cause_d;
  logic [3:0]       cur_id_q, cur_id_d;
  logic             irq_out_q, irq_out_d;
  irq_state_e       state_q, state_d;

  logic [N_SRC-1:0] rise, w1c, ack_clr, req;
  logic             ack_take, req_valid;
  logic [3:0]       req_id;
  logic             unused_wdata;

  if (SYNC_EN != 0) begin : g_sync
    logic [N_SRC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

    // Two-flop synchroniser feeding the pending logic.
    always_comb begin
      sync1_d = src_irq;
      sync2_d = sync1_q;
    end

    // Synchroniser flops.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q <= '0;
        sync2_q <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
      end
    end

    assign s = sync2_q;
  end else begin : g_nosync
    assign s = src_irq;
  end

  assign unused_wdata = ^bus.reg_wdata;

  // Register writes, edge detect and pending update (set beats any clear).
  always_comb begin
    s_prev_d   = s;
    rise       = s & ~s_prev_q;
    ack_take   = (state_q == ST_ASSERT) && bus.irq_ack;
    w1c        = (bus.reg_we && bus.reg_addr == REG_PEND) ? bus.reg_wdata[N_SRC-1:0] : '0;
    mask_d     = (bus.reg_we && bus.reg_addr == REG_MASK) ? bus.reg_wdata[N_SRC-1:0] : mask_q;
    edge_sel_d = (bus.reg_we && bus.reg_addr == REG_EDGE) ? bus.reg_wdata[N_SRC-1:0] : edge_sel_q;
    ack_clr    = '0;
    pending_d  = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      ack_clr[i] = ack_take && (cur_id_q == 4'(i));
      if (edge_sel_q[i]) pending_d[i] = rise[i] | (pending_q[i] & ~w1c[i] & ~ack_clr[i]);
      else               pending_d[i] = s[i];
    end
  end

  // Arbitration looks at next-cycle pending so a new edge raises irq_out on
  // the same edge that latches it into PENDING.
  assign req = pending_d & mask_q;

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .vec   (req),
    .valid (req_valid),
    .idx   (req_id)
  );

  // IRQ handshake FSM: next state and registered outputs.
  always_comb begin
    state_d   = state_q;
    irq_out_d = irq_out_q;
    cur_id_d  = cur_id_q;
    cause_d   = cause_q;
    case (state_q)
      ST_IDLE: begin
        irq_out_d = 1'b0;
        if (bus.irq_en_in && req_valid) begin
          cur_id_d  = req_id;
          irq_out_d = 1'b1;
          state_d   = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        irq_out_d = 1'b1;
        if (bus.irq_ack) begin
          irq_out_d = 1'b0;
          cause_d   = {12'h000, cur_id_q};
          state_d   = ST_DRAIN;
        end else if (!bus.irq_en_in) begin
          irq_out_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        irq_out_d = 1'b0;
        if (!bus.irq_en_in) state_d = ST_IDLE;
      end
      default: begin
        irq_out_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and register file flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev_q   <= '0;
      mask_q     <= '0;
      edge_sel_q <= '1;
      pending_q  <= '0;
      cause_q    <= CAUSE_NONE;
      cur_id_q   <= '0;
      irq_out_q  <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      s_prev_q   <= s_prev_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      pending_q  <= pending_d;
      cause_q    <= cause_d;
      cur_id_q   <= cur_id_d;
      irq_out_q  <= irq_out_d;
      state_q    <= state_d;
    end
  end

  assign bus.irq_out = irq_out_q;

  // Combinational register read; vector bits above N_SRC read as zero.
  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      REG_MASK:  bus.reg_rdata = 16'(mask_q);
      REG_PEND:  bus.reg_rdata = 16'(pending_q);
      REG_EDGE:  bus.reg_rdata = 16'(edge_sel_q);
      REG_CAUSE: bus.reg_rdata = cause_q;
      default:   bus.reg_rdata = '0;
    endcase
  end

endmodule
